// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one request outstanding to
// instruction memory and hands fetched words to decode through a valid/stall slot.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPc,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    output logic [31:0] Pc,
    output logic        IfValid,
    output logic [31:0] IfPc,
    output logic [31:0] Inst
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc_next;
    logic [31:0] buf_inst;
    logic [31:0] slot_data;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        slot_free;
    logic        slot_load;
    logic        buf_load;

    // Masking keeps every target word-aligned without leaving RedirectPc bits unused.
    assign redirect_target = RedirectPc & 32'hFFFF_FFFC;
    assign pc_plus4        = Pc + 32'd4;
    assign slot_free       = !IfValid || !Stall;

    assign ImemReq  = (state == ST_REQ) && !Rst;
    assign ImemAddr = Pc;

    always_comb begin
        state_next = state;
        pc_next    = Pc;
        slot_load  = 1'b0;
        slot_data  = ImemData;
        buf_load   = 1'b0;

        case (state)
            ST_REQ: begin
                if (Redirect) begin
                    pc_next = redirect_target;
                    if (ImemGnt) begin
                        state_next = ST_DROP;
                    end
                end else if (ImemGnt) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (Redirect) begin
                    pc_next    = redirect_target;
                    state_next = ImemValid ? ST_REQ : ST_DROP;
                end else if (ImemValid) begin
                    if (slot_free) begin
                        slot_load  = 1'b1;
                        pc_next    = pc_plus4;
                        state_next = ST_REQ;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end

            // The skid buffer drains as soon as decode stops stalling.
            ST_HOLD: begin
                if (Redirect) begin
                    pc_next    = redirect_target;
                    state_next = ST_REQ;
                end else if (!Stall) begin
                    slot_load  = 1'b1;
                    slot_data  = buf_inst;
                    pc_next    = pc_plus4;
                    state_next = ST_REQ;
                end
            end

            ST_DROP: begin
                if (Redirect) begin
                    pc_next = redirect_target;
                end
                if (ImemValid) begin
                    state_next = ST_REQ;
                end
            end

            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_REQ;
            Pc       <= RESET_PC;
            IfValid  <= 1'b0;
            IfPc     <= 32'h0;
            Inst     <= NOP_INST;
            buf_inst <= 32'h0;
        end else begin
            state <= state_next;
            Pc    <= pc_next;
            if (buf_load) begin
                buf_inst <= ImemData;
            end
            // A redirect flushes the slot even when decode is stalled.
            if (Redirect) begin
                IfValid <= 1'b0;
                Inst    <= NOP_INST;
            end else if (slot_load) begin
                IfValid <= 1'b1;
                IfPc    <= Pc;
                Inst    <= slot_data;
            end else if (slot_free) begin
                IfValid <= 1'b0;
                Inst    <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic, all
// compared against a flag-based transaction model of the fetch pipeline.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemValid;
    logic [31:0] ImemData;
    logic [31:0] Pc;
    logic        IfValid;
    logic [31:0] IfPc;
    logic [31:0] Inst;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    // Reference model: outstanding/discard/held flags instead of a state machine.
    logic [31:0] m_pc, m_ifpc, m_inst, m_hdata;
    bit          m_out, m_disc, m_held, m_v;

    bit          mem_pending;
    int          mem_due;
    logic [31:0] mem_rdata;
    bit          mem_override_en;
    logic [31:0] mem_override;

    bit          exp_pc_en;
    logic [31:0] exp_pc;
    bit          exp_inst_en;
    logic [31:0] exp_inst;

    fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect), .RedirectPc(RedirectPc),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt), .ImemValid(ImemValid),
        .ImemData(ImemData), .Pc(Pc), .IfValid(IfValid), .IfPc(IfPc), .Inst(Inst)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit stall, input bit redir,
                                 input logic [31:0] rpc, input bit gnt, input bit vld,
                                 input logic [31:0] data);
        Rst        = rst;
        Stall      = stall;
        Redirect   = redir;
        RedirectPc = rpc;
        ImemGnt    = gnt;
        ImemValid  = vld;
        ImemData   = data;
    endtask

    task automatic modelReset();
        m_pc   = RESET_PC;
        m_ifpc = 32'h0;
        m_inst = NOP_INST;
        m_out  = 1'b0;
        m_disc = 1'b0;
        m_held = 1'b0;
        m_v    = 1'b0;
    endtask

    task automatic modelStep();
        bit          free;
        bit          req;
        bit          load;
        logic [31:0] ldata;
        load  = 1'b0;
        ldata = 32'h0;
        if (Rst) begin
            modelReset();
        end else begin
            free = !m_v || !Stall;
            req  = !m_out && !m_held;
            if (Redirect) begin
                m_pc = RedirectPc & 32'hFFFF_FFFC;
                if (req && ImemGnt) begin
                    m_out  = 1'b1;
                    m_disc = 1'b1;
                end else if (m_out && ImemValid) begin
                    m_out = 1'b0;
                end else if (m_out) begin
                    m_disc = 1'b1;
                end
                m_held = 1'b0;
                m_v    = 1'b0;
                m_inst = NOP_INST;
            end else begin
                if (req && ImemGnt) begin
                    m_out  = 1'b1;
                    m_disc = 1'b0;
                end else if (m_out && ImemValid) begin
                    m_out = 1'b0;
                    if (m_disc) begin
                        m_disc = 1'b0;
                    end else if (free) begin
                        load  = 1'b1;
                        ldata = ImemData;
                    end else begin
                        m_held  = 1'b1;
                        m_hdata = ImemData;
                    end
                end else if (m_held && !Stall) begin
                    load   = 1'b1;
                    ldata  = m_hdata;
                    m_held = 1'b0;
                end
                if (load) begin
                    m_v    = 1'b1;
                    m_ifpc = m_pc;
                    m_inst = ldata;
                    m_pc   = m_pc + 32'd4;
                end else if (free) begin
                    m_v    = 1'b0;
                    m_inst = NOP_INST;
                end
            end
        end
    endtask

    // One clock: check registered outputs, drive memory and control, check the request.
    task automatic doCycle(input bit rst, input bit stall, input bit redir,
                           input logic [31:0] rpc, input bit gnt_ok, input int dly);
        bit          vld;
        bit          gnt;
        logic [31:0] rd;
        @(posedge Clk);
        #1;
        checkOutput("pc", Pc, m_pc);
        checkOutput("if_valid", 32'(IfValid), 32'(m_v));
        checkOutput("if_pc", IfPc, m_ifpc);
        checkOutput("inst", Inst, m_inst);
        if (exp_pc_en) begin
            checkOutput("pc_directed", Pc, exp_pc);
            exp_pc_en = 1'b0;
        end
        if (exp_inst_en) begin
            checkOutput("inst_directed", Inst, exp_inst);
            exp_inst_en = 1'b0;
        end
        vld = mem_pending && (mem_due == cyc);
        rd  = vld ? mem_rdata : $urandom();
        gnt = gnt_ok && !rst && !m_out && !m_held && !mem_pending;
        applyStimulus(rst, stall, redir, rpc, gnt, vld, rd);
        if (vld) mem_pending = 1'b0;
        if (gnt) begin
            mem_pending     = 1'b1;
            mem_due         = cyc + dly;
            mem_rdata       = mem_override_en ? mem_override : memFn(m_pc);
            mem_override_en = 1'b0;
        end
        #1;
        checkOutput("imem_req", 32'(ImemReq), 32'(!m_out && !m_held && !rst));
        checkOutput("imem_addr", ImemAddr, m_pc);
        modelStep();
        cyc++;
    endtask

    task automatic settle();
        for (int i = 0; i < 12 && (m_out || m_held || mem_pending); i++) begin
            doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        modelReset();
        mem_pending     = 1'b0;
        mem_due         = 0;
        mem_rdata       = 32'h0;
        mem_override_en = 1'b0;
        mem_override    = 32'h0;
        exp_pc_en       = 1'b0;
        exp_inst_en     = 1'b0;

        doCycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        doCycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        exp_pc_en = 1'b1;
        exp_pc    = RESET_PC;
        for (int i = 0; i < 10; i++) doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // Skid: slot full and stalled when the next word returns.
        for (int i = 0; i < 10 && !(m_v && !m_out && !m_held && !mem_pending); i++)
            doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        mem_override_en = 1'b1;
        mem_override    = 32'hDEAD_BEEF;
        doCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1);
        for (int i = 0; i < 4; i++) doCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1);
        doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        exp_inst_en = 1'b1;
        exp_inst    = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // Redirect while waiting on a fetch at 8.
        settle();
        doCycle(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 1);
        doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
        doCycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1);
        for (int i = 0; i < 8; i++) doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // Redirect together with the response, then together with the grant.
        settle();
        doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        doCycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1);
        for (int i = 0; i < 4; i++) doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        settle();
        doCycle(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 2);
        for (int i = 0; i < 6; i++) doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // Alignment and wrap.
        settle();
        doCycle(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b0, 1);
        exp_pc_en = 1'b1;
        exp_pc    = 32'h0000_0200;
        doCycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1);
        for (int i = 0; i < 6; i++) doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        // Reset while a slow response is in flight.
        settle();
        doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
        doCycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1);
        exp_pc_en = 1'b1;
        exp_pc    = RESET_PC;
        for (int i = 0; i < 8; i++) doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);

        for (int i = 0; i < 2500; i++) begin
            doCycle($urandom_range(199) == 0, $urandom_range(2) == 0, $urandom_range(9) == 0,
                    ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom(),
                    $urandom_range(2) != 0, int'($urandom_range(3, 1)));
        end
        doCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the architectural PC register and drives the PC consumed by `npc`. It issues one-outstanding requests to instruction memory and presents fetched instructions to decode through a valid/stall handshake. It applies redirects from `npc` (taken branch, JAL, JALR), discarding any wrong-path instruction in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, value of `Inst` whenever `IfValid`=0.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Stall  in  1  decode cannot accept; hold the output slot.
- Redirect  in  1  control transfer resolved this cycle.
- RedirectPc  in  32  target; driven from `npc` output `Npc`.
- ImemReq  out  1  fetch request.
- ImemAddr  out  32  fetch address; always equals `Pc`.
- ImemGnt  in  1  request accepted this cycle.
- ImemValid  in  1  response data valid; at least 1 cycle after grant.
- ImemData  in  32  response instruction.
- Pc  out  32  current fetch PC, feeds `npc.Pc`.
- IfValid  out  1  `Inst`/`IfPc` hold a valid instruction.
- IfPc  out  32  PC of `Inst`.
- Inst  out  32  instruction to decode.

## Operation
- States: REQ, WAIT, HOLD, DROP. Memory has at most one outstanding request.
- `ImemReq` = (state==REQ) && !Rst. It is combinational from state only, with no path from `Redirect`.
- The output slot is free when !IfValid || !Stall.
- Priority in every state: Rst > Redirect > memory events.

State behaviour:
- REQ:
  - Redirect && ImemGnt: Pc<=RedirectPc, go to DROP.
  - Redirect only: Pc<=RedirectPc, stay in REQ.
  - ImemGnt: go to WAIT.
- WAIT:
  - Redirect && ImemValid: drop the data, Pc<=RedirectPc, go to REQ.
  - Redirect only: Pc<=RedirectPc, go to DROP.
  - ImemValid with the slot free: load the slot (IfValid<=1, IfPc<=Pc, Inst<=ImemData), Pc<=Pc+4, go to REQ.
  - ImemValid with the slot busy: BufInst<=ImemData, go to HOLD.
- HOLD:
  - Redirect: drop BufInst, Pc<=RedirectPc, go to REQ.
  - !Stall: load the slot from BufInst with IfPc<=Pc, Pc<=Pc+4, go to REQ.
- DROP:
  - Discard the next ImemValid, then go to REQ.
  - Redirect: Pc<=RedirectPc. If ImemValid is high in the same cycle, go to REQ; otherwise stay in DROP.

Output slot:
- Redirect forces IfValid<=0 (flush) regardless of Stall.
- When the slot is free and nothing loads, IfValid<=0.
- When IfValid && Stall, IfPc and Inst are held unchanged.

Arithmetic and boundaries:
- Pc+4 is 32-bit and wraps: 32'hFFFF_FFFC becomes 32'h0.
- RedirectPc[1:0] is forced to 2'b00 on load.
- Redirect takes effect even while Stall=1.
- ImemValid outside WAIT/DROP is ignored.

## Timing
- Reset values: Pc=RESET_PC, state=REQ, ImemReq=0, IfValid=0, IfPc=32'h0, Inst=NOP_INST, BufInst=32'h0.
- ImemReq rises in the first cycle after Rst falls.
- Minimum fetch latency:
  - Grant in cycle t.
  - ImemValid in t+1.
  - IfValid=1 in t+2.
  - Next request in t+2.
- Peak throughput is one instruction per 2 cycles, with single-cycle grant and response.
- A redirect in cycle t changes Pc at t+1, so `npc` sees the new Pc one cycle later.
- The first request to the new target is issued:
  - at t+1, if no response is outstanding;
  - otherwise in the cycle after the stale response arrives.
- Rst asserted in any state returns to the reset values at the next edge. An outstanding memory response arriving after reset is ignored: the state is REQ with no grant pending.

## Test plan
- Sequential fetch: Rst for 2 cycles, then grant and 1-cycle response each request; Stall=0.
  - IfPc sequence 0, 4, 8, 12 with IfValid pulses every 2 cycles.
  - Inst matches memory contents.
- Stall with skid:
  - Setup: IfValid=1 and Stall=1 when ImemValid returns data 32'hDEAD_BEEF.
  - While Stall=1: state HOLD, Pc unchanged, slot unchanged.
  - Release Stall: Inst=32'hDEAD_BEEF at the next edge, and Pc advances by 4.
- Redirect in WAIT:
  - Setup: grant at Pc=8, Redirect with RedirectPc=32'h100 before the response.
  - The stale response is discarded (IfValid stays 0).
  - The next ImemAddr is 32'h100.
- Simultaneous events:
  - Redirect and ImemValid together in WAIT: data dropped, and ImemReq with ImemAddr=RedirectPc next cycle.
  - Redirect and ImemGnt together in REQ: state DROP.
- Wrap and alignment:
  - Pc=32'hFFFF_FFFC fetch completes, so the next ImemAddr=32'h0.
  - RedirectPc=32'h0000_0203 loads Pc=32'h0000_0200.
- Reset mid-operation:
  - Rst asserted in WAIT with a response arriving 2 cycles later.
  - All outputs at their reset values, the late response is ignored, and the first fetch after reset is from RESET_PC.
